// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: program-memory port plus the decode/stall-control
// side of the fetch stage. The fetch unit is the master.
interface instr_fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);
  // control from stall control / execute
  logic               stall;
  logic               stall_pm;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  // program memory
  logic [PC_W-1:0]    pm_addr;
  logic [INSTR_W-1:0] pm_rdata;
  // to decode / stall control
  logic [INSTR_W-1:0] instr;
  logic [5:0]         op;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               halted;

  modport master (
    input  stall, stall_pm, redirect, redirect_pc, pm_rdata,
    output pm_addr, instr, op, instr_pc, instr_valid, halted
  );

  modport slave (
    output stall, stall_pm, redirect, redirect_pc, pm_rdata,
    input  pm_addr, instr, op, instr_pc, instr_valid, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the program-memory address,
// presents the fetched word (or a replayed held word) to decode, handles
// jump redirects and stops on HLT.
// Optional feature macro: IFU_RESUME_EN adds a resume input that restarts
// fetch from HALT.
module instr_fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef IFU_RESUME_EN
  input  logic                  resume,
`endif
  instr_fetch_unit_if.master    bus
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;
  localparam logic [5:0] OP_HLT  = 6'b010001;

  logic [1:0]         state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt, prev_pc, hold_pc, cur_pc;
  logic [INSTR_W-1:0] hold_instr, cur_instr;
  logic               halt_det, do_resume;

  // Presented word: replay the held word when stall control asks for it.
  // Forced to zero while reset is asserted so decode never sees stale data.
  always_comb begin
    cur_instr = '0;
    if (reset) cur_instr = bus.stall_pm ? hold_instr : bus.pm_rdata;
    cur_pc = bus.stall_pm ? hold_pc : prev_pc;
  end

  assign bus.pm_addr     = pc;
  assign bus.instr       = cur_instr;
  assign bus.op          = cur_instr[INSTR_W-1 -: 6];
  assign bus.instr_pc    = cur_pc;
  assign bus.instr_valid = (state == S_RUN);
  assign bus.halted      = (state == S_HALT);

  // HLT only counts on a live, non-replayed word; a same-cycle jump wins.
  assign halt_det = (state == S_RUN) && (cur_instr[INSTR_W-1 -: 6] == OP_HLT)
                    && !bus.stall_pm && !bus.redirect;

`ifdef IFU_RESUME_EN
  assign do_resume = (state == S_HALT) && resume;
`else
  assign do_resume = 1'b0;
`endif

  // Next-state: FILL/FLUSH are single bubble cycles covering memory latency.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  state_nxt = S_RUN;
      S_RUN:   if (bus.redirect) state_nxt = S_FLUSH;
               else if (halt_det) state_nxt = S_HALT;
      S_FLUSH: state_nxt = S_RUN;
      S_HALT:  if (do_resume) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  // Next PC: redirect > halt hold > stall hold > increment (wraps silently).
  // While halted the PC already sits at HLT address + 1, so holding it on
  // resume restarts fetch right after the HLT word.
  always_comb begin
    pc_nxt = pc + PC_W'(1);
    if (bus.redirect && state != S_HALT) pc_nxt = bus.redirect_pc;
    else if (state == S_HALT || halt_det) pc_nxt = pc;
    else if (bus.stall)                   pc_nxt = pc;
  end

  // State, PC and replay registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FILL;
      pc         <= RESET_PC;
      prev_pc    <= RESET_PC;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      prev_pc    <= pc;
      hold_instr <= cur_instr;
      hold_pc    <= cur_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: mem[i] = i, with an optional HLT word.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic resume = 1'b0;
  logic hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0003;
  int n_chk = 0;
  int n_fail = 0;

  instr_fetch_unit_if #(.PC_W(16), .INSTR_W(32)) bus ();

  instr_fetch_unit #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef IFU_RESUME_EN
    .resume(resume),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] w;
    w = {16'h0000, a};
    if (hlt_en && a == hlt_addr) w[31:26] = 6'b010001;
    return w;
  endfunction

  // synchronous program memory, 1-cycle read latency
  always @(posedge clk) bus.pm_rdata <= mem_word(bus.pm_addr);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", bus.instr); end
    step(); step();
    n_chk++; if (bus.pm_addr !== 16'h0) begin n_fail++; $display("FAIL rst_pm_addr got %h exp 0", bus.pm_addr); end
    n_chk++; if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_flags got v=%b h=%b exp 0 0", bus.instr_valid, bus.halted); end
    n_chk++; if (bus.instr !== 32'h0 || bus.op !== 6'h0) begin n_fail++; $display("FAIL rst_instr_op got %h/%h exp 0/0", bus.instr, bus.op); end
    reset = 1'b1;
    #1;
    n_chk++; if (bus.instr_valid !== 1'b0 || bus.pm_addr !== 16'h0) begin n_fail++; $display("FAIL fill_bubble got v=%b a=%h exp 0 0", bus.instr_valid, bus.pm_addr); end
  endtask

  task automatic test_fetch();
    for (int k = 1; k <= 5; k++) begin
      step();
      n_chk++;
      if (bus.pm_addr !== 16'(k) || bus.instr !== 32'(k-1) || bus.instr_pc !== 16'(k-1) || bus.instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch_%0d got a=%h i=%h pc=%h v=%b exp a=%h i=%h pc=%h v=1", k, bus.pm_addr, bus.instr, bus.instr_pc, bus.instr_valid, 16'(k), 32'(k-1), 16'(k-1));
      end
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    step();
    n_chk++; if (bus.pm_addr !== 16'h5) begin n_fail++; $display("FAIL stall1_addr got %h exp 0005", bus.pm_addr); end
    bus.stall_pm = 1'b1;
    #1;
    n_chk++; if (bus.instr !== 32'h4 || bus.instr_pc !== 16'h4) begin n_fail++; $display("FAIL replay got i=%h pc=%h exp 4 4", bus.instr, bus.instr_pc); end
    step();
    n_chk++; if (bus.pm_addr !== 16'h5 || bus.instr !== 32'h4) begin n_fail++; $display("FAIL stall2 got a=%h i=%h exp 5 4", bus.pm_addr, bus.instr); end
    step();
    n_chk++; if (bus.pm_addr !== 16'h5 || bus.instr_pc !== 16'h4) begin n_fail++; $display("FAIL stall3 got a=%h pc=%h exp 5 4", bus.pm_addr, bus.instr_pc); end
    bus.stall = 1'b0;
    bus.stall_pm = 1'b0;
    step();
    n_chk++; if (bus.pm_addr !== 16'h6 || bus.instr !== 32'h5 || bus.instr_pc !== 16'h5) begin n_fail++; $display("FAIL unstall got a=%h i=%h pc=%h exp 6 5 5", bus.pm_addr, bus.instr, bus.instr_pc); end
    // replay without stall: PC keeps advancing
    bus.stall_pm = 1'b1;
    step();
    n_chk++; if (bus.pm_addr !== 16'h7 || bus.instr !== 32'h5 || bus.instr_pc !== 16'h5) begin n_fail++; $display("FAIL pm_only got a=%h i=%h pc=%h exp 7 5 5", bus.pm_addr, bus.instr, bus.instr_pc); end
    bus.stall_pm = 1'b0;
    #1;
    n_chk++; if (bus.instr !== 32'h6 || bus.instr_pc !== 16'h6) begin n_fail++; $display("FAIL pm_release got i=%h pc=%h exp 6 6", bus.instr, bus.instr_pc); end
  endtask

  task automatic test_redirect();
    step();
    n_chk++; if (bus.pm_addr !== 16'h8) begin n_fail++; $display("FAIL pre_jump_addr got %h exp 0008", bus.pm_addr); end
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
    step();
    bus.redirect = 1'b0;
    n_chk++; if (bus.pm_addr !== 16'h0040 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL jump_flush got a=%h v=%b exp 0040 0", bus.pm_addr, bus.instr_valid); end
    step();
    n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h40 || bus.instr_pc !== 16'h0040 || bus.pm_addr !== 16'h0041) begin n_fail++; $display("FAIL jump_target got v=%b i=%h pc=%h a=%h exp 1 40 0040 0041", bus.instr_valid, bus.instr, bus.instr_pc, bus.pm_addr); end
    // redirect beats stall
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0080; bus.stall = 1'b1;
    step();
    bus.redirect = 1'b0; bus.stall = 1'b0;
    n_chk++; if (bus.pm_addr !== 16'h0080) begin n_fail++; $display("FAIL jump_vs_stall got %h exp 0080", bus.pm_addr); end
    step();
    n_chk++; if (bus.instr !== 32'h80 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL jump_vs_stall_tgt got i=%h v=%b exp 80 1", bus.instr, bus.instr_valid); end
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
    step();
    bus.redirect = 1'b0;
    step();
    n_chk++; if (bus.pm_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got %h exp ffff", bus.pm_addr); end
    step();
    n_chk++; if (bus.pm_addr !== 16'h0000 || bus.instr_pc !== 16'hFFFF || bus.instr !== 32'hFFFF) begin n_fail++; $display("FAIL wrap got a=%h pc=%h i=%h exp 0000 ffff ffff", bus.pm_addr, bus.instr_pc, bus.instr); end
  endtask

  task automatic test_reset_mid();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h001E;
    step();
    bus.redirect = 1'b0;
    step(); step();
    n_chk++; if (bus.pm_addr !== 16'h0020 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got a=%h v=%b exp 0020 1", bus.pm_addr, bus.instr_valid); end
    reset = 1'b0;
    #1;
    n_chk++; if (bus.pm_addr !== 16'h0 || bus.instr_valid !== 1'b0 || bus.instr !== 32'h0) begin n_fail++; $display("FAIL mid_async got a=%h v=%b i=%h exp 0 0 0", bus.pm_addr, bus.instr_valid, bus.instr); end
    step();
    reset = 1'b1;
    #1;
    n_chk++; if (bus.pm_addr !== 16'h0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_fill got a=%h v=%b exp 0 0", bus.pm_addr, bus.instr_valid); end
    step();
    n_chk++; if (bus.pm_addr !== 16'h1 || bus.instr !== 32'h0 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_restart got a=%h i=%h v=%b exp 1 0 1", bus.pm_addr, bus.instr, bus.instr_valid); end
  endtask

  task automatic test_hlt_redirect();
    hlt_en = 1'b1;
    do_reset();
    step(); step(); step(); step();
    n_chk++; if (bus.op !== 6'b010001 || bus.instr_valid !== 1'b1 || bus.pm_addr !== 16'h4) begin n_fail++; $display("FAIL hlt_seen got op=%b v=%b a=%h exp 010001 1 0004", bus.op, bus.instr_valid, bus.pm_addr); end
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0010;
    step();
    bus.redirect = 1'b0;
    n_chk++; if (bus.halted !== 1'b0 || bus.pm_addr !== 16'h0010) begin n_fail++; $display("FAIL hlt_vs_jump got h=%b a=%h exp 0 0010", bus.halted, bus.pm_addr); end
    step();
    n_chk++; if (bus.instr !== 32'h10 || bus.instr_valid !== 1'b1 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL hlt_vs_jump_tgt got i=%h v=%b h=%b exp 10 1 0", bus.instr, bus.instr_valid, bus.halted); end
  endtask

  task automatic test_halt();
    do_reset();
    step(); step(); step(); step();
    n_chk++; if (bus.halted !== 1'b0 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL halt_det_cycle got h=%b v=%b exp 0 1", bus.halted, bus.instr_valid); end
    step();
    n_chk++; if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pm_addr !== 16'h4) begin n_fail++; $display("FAIL halt got h=%b v=%b a=%h exp 1 0 0004", bus.halted, bus.instr_valid, bus.pm_addr); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++; if (bus.halted !== 1'b1 || bus.pm_addr !== 16'h4) begin n_fail++; $display("FAIL halt_hold_%0d got h=%b a=%h exp 1 0004", k, bus.halted, bus.pm_addr); end
    end
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
    step();
    bus.redirect = 1'b0;
    n_chk++; if (bus.pm_addr !== 16'h4 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_jump got a=%h h=%b exp 0004 1", bus.pm_addr, bus.halted); end
`ifdef IFU_RESUME_EN
    resume = 1'b1;
    step();
    resume = 1'b0;
    n_chk++; if (bus.halted !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pm_addr !== 16'h4) begin n_fail++; $display("FAIL resume_fill got h=%b v=%b a=%h exp 0 0 0004", bus.halted, bus.instr_valid, bus.pm_addr); end
    step();
    n_chk++; if (bus.instr !== 32'h4 || bus.instr_pc !== 16'h4 || bus.instr_valid !== 1'b1 || bus.pm_addr !== 16'h5) begin n_fail++; $display("FAIL resume_run got i=%h pc=%h v=%b a=%h exp 4 0004 1 0005", bus.instr, bus.instr_pc, bus.instr_valid, bus.pm_addr); end
`endif
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.stall_pm = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_hlt_redirect();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
